// File: rtl/fp_add_seq_if.sv
// Handshake and operand/result bus for the sequential floating-point adder.
// Format is sign-magnitude {sign, exp[EXP_W], man[MAN_W]} with an explicit mantissa MSB.
interface fp_add_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         overflow;
    logic         zero;

    modport master (
        output start, op, a, b,
        input  busy, done, r, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, r, overflow, zero
    );
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle sign-magnitude floating-point add/subtract: compare, serial align,
// add, serial normalise. Truncates, saturates on exponent overflow, keeps denormals.
module fp_add_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    fp_add_seq_if.slave  bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMP   = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] NORM  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Control and visible result state (reset)
    logic [2:0]       state_q, state_d;
    logic [W-1:0]     r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Datapath working registers (not reset)
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic             sign_q, sign_d;
    logic             eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic [MAN_W-1:0] xman_q, xman_d;
    logic [MAN_W-1:0] yman_q, yman_d;
    logic [MAN_W:0]   man_q, man_d;

    logic             a_s, b_s, b_larger;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;

    function automatic logic [W-1:0] saturate(input logic s);
        saturate = {s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    endfunction

    // B's sign is flipped for subtraction so the rest of the datapath only adds magnitudes.
    assign a_s      = a_q[W-1];
    assign a_e      = a_q[W-2:MAN_W];
    assign a_m      = a_q[MAN_W-1:0];
    assign b_s      = b_q[W-1] ^ op_q;
    assign b_e      = b_q[W-2:MAN_W];
    assign b_m      = b_q[MAN_W-1:0];
    assign b_larger = (b_e > a_e) || ((b_e == a_e) && (b_m > a_m));

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        xman_d    = xman_q;
        yman_d    = yman_q;
        man_d     = man_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                eff_sub_d = a_s ^ b_s;
                if (b_larger) begin
                    sign_d = b_s;
                    exp_d  = b_e;
                    xman_d = b_m;
                    yman_d = a_m;
                    cnt_d  = b_e - a_e;
                end else begin
                    sign_d = a_s;
                    exp_d  = a_e;
                    xman_d = a_m;
                    yman_d = b_m;
                    cnt_d  = a_e - b_e;
                end
                // Beyond MAN_W every bit of Y would shift out anyway; skip the walk.
                if (32'(cnt_d) > 32'(MAN_W)) begin
                    yman_d = '0;
                    cnt_d  = '0;
                end
                state_d = ALIGN;
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else begin
                    yman_d = yman_q >> 1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            ADD: begin
                man_d   = eff_sub_q ? ({1'b0, xman_q} - {1'b0, yman_q})
                                    : ({1'b0, xman_q} + {1'b0, yman_q});
                state_d = NORM;
            end
            NORM: begin
                if (man_q[MAN_W]) begin
                    if (&exp_q) begin
                        ovf_d   = 1'b1;
                        r_d     = saturate(sign_q);
                        state_d = DONE;
                    end else begin
                        man_d = man_q >> 1;
                        exp_d = exp_q + 1'b1;
                    end
                end else if (man_q == '0) begin
                    zero_d  = 1'b1;
                    r_d     = '0;
                    state_d = DONE;
                end else if (!man_q[MAN_W-1] && (exp_q != '0)) begin
                    man_d = man_q << 1;
                    exp_d = exp_q - 1'b1;
                end else begin
                    r_d     = {sign_q, exp_q, man_q[MAN_W-1:0]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_ff @(posedge clk_i) begin
        a_q       <= a_d;
        b_q       <= b_d;
        op_q      <= op_d;
        sign_q    <= sign_d;
        eff_sub_q <= eff_sub_d;
        exp_q     <= exp_d;
        cnt_q     <= cnt_d;
        xman_q    <= xman_d;
        yman_q    <= yman_d;
        man_q     <= man_d;
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.r        = r_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq (EXP_W=8, MAN_W=24) with hand-computed results and latencies.
module tb_fp_add_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    fp_add_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_add_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] fp(input logic s, input logic [7:0] e, input logic [23:0] m);
        fp = {s, e, m};
    endfunction

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Issues one operation and checks latency, result, flags and the single-cycle done pulse.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] exp_r, input logic exp_ovf,
                          input logic exp_zero, input int exp_lat, input bit glitch);
        int n;
        bit seen;
        logic [W-1:0] r_seen;
        logic ovf_seen, zero_seen;
        seen = 1'b0;
        r_seen = '0;
        ovf_seen = 1'b0;
        zero_seen = 1'b0;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.op = op;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk1({tag, " busy"}, bus.busy, 1'b1);
        chk1({tag, " ovf cleared"}, bus.overflow, 1'b0);
        chk1({tag, " zero cleared"}, bus.zero, 1'b0);
        n = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (glitch && n == 2) begin
                bus.a = fp(1'b0, 8'h30, 24'hFFFFFF);
                bus.b = fp(1'b1, 8'h01, 24'h800000);
                bus.op = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                r_seen = bus.r;
                ovf_seen = bus.overflow;
                zero_seen = bus.zero;
            end
        end
        chk1({tag, " done seen"}, seen, 1'b1);
        chkn({tag, " latency"}, n, exp_lat);
        chkw({tag, " r"}, r_seen, exp_r);
        chk1({tag, " overflow"}, ovf_seen, exp_ovf);
        chk1({tag, " zero"}, zero_seen, exp_zero);
        @(posedge clk);
        #1;
        chk1({tag, " done pulse ends"}, bus.done, 1'b0);
        chk1({tag, " idle"}, bus.busy, 1'b0);
        chkw({tag, " r held"}, bus.r, exp_r);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset busy", bus.busy, 1'b0);
        chk1("reset done", bus.done, 1'b0);
        chkw("reset r", bus.r, '0);
        chk1("reset ovf", bus.overflow, 1'b0);
        chk1("reset zero", bus.zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add carry", fp(0, 8'h10, 24'h800000), fp(0, 8'h10, 24'h800000), 1'b0,
               fp(0, 8'h11, 24'h800000), 1'b0, 1'b0, 5, 1'b0);
        run_op("sub swap", fp(0, 8'h10, 24'h800000), fp(0, 8'h11, 24'h800000), 1'b1,
               fp(1, 8'h10, 24'h800000), 1'b0, 1'b0, 6, 1'b0);
        run_op("sub equal", fp(0, 8'h20, 24'hABCDEF), fp(0, 8'h20, 24'hABCDEF), 1'b1,
               '0, 1'b0, 1'b1, 4, 1'b0);
        run_op("add far", fp(0, 8'h40, 24'hC00000), fp(0, 8'h22, 24'hFFFFFF), 1'b0,
               fp(0, 8'h40, 24'hC00000), 1'b0, 1'b0, 4, 1'b0);
        run_op("sub denorm", fp(0, 8'h10, 24'h800000), fp(0, 8'h10, 24'h7FFFFF), 1'b1,
               fp(0, 8'h00, 24'h010000), 1'b0, 1'b0, 20, 1'b0);
        run_op("overflow", fp(0, 8'hFF, 24'h800000), fp(0, 8'hFF, 24'h800000), 1'b0,
               fp(0, 8'hFF, 24'hFFFFFF), 1'b1, 1'b0, 4, 1'b0);
        run_op("mixed sign", fp(1, 8'h10, 24'h800000), fp(0, 8'h10, 24'hC00000), 1'b0,
               fp(0, 8'h0F, 24'h800000), 1'b0, 1'b0, 5, 1'b0);
        run_op("sub neg b", fp(0, 8'h10, 24'h800000), fp(1, 8'h0F, 24'h800000), 1'b1,
               fp(0, 8'h10, 24'hC00000), 1'b0, 1'b0, 5, 1'b0);
        run_op("start ignored", fp(0, 8'h18, 24'h800000), fp(0, 8'h10, 24'h800000), 1'b0,
               fp(0, 8'h18, 24'h808000), 1'b0, 1'b0, 12, 1'b1);

        // Abort during ALIGN with an asynchronous reset between clock edges.
        @(negedge clk);
        bus.a = fp(0, 8'h18, 24'h800000);
        bus.b = fp(0, 8'h10, 24'h800000);
        bus.op = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("abort busy", bus.busy, 1'b0);
        chk1("abort done", bus.done, 1'b0);
        chkw("abort r", bus.r, '0);
        chk1("abort ovf", bus.overflow, 1'b0);
        chk1("abort zero", bus.zero, 1'b0);
        dcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dcount++;
        end
        chkn("abort no done", dcount, 0);
        run_op("after abort", fp(0, 8'h18, 24'h800000), fp(0, 8'h10, 24'h800000), 1'b0,
               fp(0, 8'h18, 24'h808000), 1'b0, 1'b0, 12, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
